quad_decoder: RTL
=================

# quad_decoder

Quadrature decoder with an integrated position counter. It is the input side of the up/down counter path: it turns two phase-shifted encoder signals (A/B) and an index pulse into single-cycle step/direction events, and it keeps a loadable N-bit position count. It sits between the board-level encoder pins and any logic that consumes a position or step stream.

## Interface
Parameters:
- N, 8, width of the position counter (≥2)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- a_in  input  1  encoder phase A, asynchronous to clk
- b_in  input  1  encoder phase B, asynchronous to clk
- idx_in  input  1  encoder index, asynchronous; rising edge zeroes the count
- en_load  input  1  synchronous load strobe
- load  input  N  value written to cnt when en_load=1
- step  output  1  one-cycle pulse per valid quadrature transition
- dir  output  1  direction of the last step (1 = up, 0 = down)
- cnt  output  N  position count
- err  output  1  sticky illegal-transition flag

## Operation
- Each of a_in, b_in and idx_in passes through a 2-flop synchronizer. Decode uses only the second flop (a_s, b_s, i_s) and the registered previous values (a_p, b_p, i_p).
- Phase code {a,b}. The up sequence is 00→10→11→01→00. The reverse sequence is down.
- Per cycle, compare {a_s,b_s} with {a_p,b_p}:
  - equal: no event.
  - one bit changed, up order: step=1, dir=1, cnt+1.
  - one bit changed, down order: step=1, dir=0, cnt−1.
  - both bits changed: illegal. err←1, no step, cnt and dir unchanged.
- Arithmetic is modulo 2^N. 2^N−1 +1 → 0. 0 −1 → 2^N−1.
- Counter update priority, highest first: rst > en_load (cnt←load) > index rising edge (i_s=1, i_p=0; cnt←0) > step.
  - step and dir are still asserted when a valid transition loses priority to en_load or the index.
- err is cleared only by rst or en_load. The error is sticky across further illegal transitions.
- FSM states:
  - PRIME: entered on rst. Lasts 2 cycles, so the synchronizers fill with live pin values. a_p/b_p/i_p track a_s/b_s/i_s, no decode, step=0, no index clear. → RUN after the 2nd cycle.
  - RUN: normal decode. Stays in RUN until rst.
  - en_load is honored in both states.
- Reset values: step=0, dir=1, cnt=0, err=0, all sync/prev flops 0, state=PRIME.
- rst asserted mid-operation overrides everything on that edge. In-flight transitions in the synchronizers are discarded.

## Timing
- Pin change settled before edge E0: ff1 captures at E0, ff2 (a_s) at E1, and step/dir/cnt register at E2. Latency is 2 edges from first capture; step is high during the cycle after E2.
- step is high for exactly one cycle per transition. A new transition every cycle yields step high continuously with a cnt change each cycle. Maximum rate is 1 transition per clk; faster inputs alias and may flag err.
- en_load: cnt=load and err=0 on the edge where en_load is sampled high. Visible the next cycle.
- After rst deasserts at edge R: PRIME for edges R+1 and R+2. The first decode is possible at R+3.
- Index clear follows the same 2-edge latency as A/B.

## Structure
- Shared package quad_pkg holds:
  - DIR_UP=1'b1, DIR_DN=1'b0.
  - Phase encoding constants PH0=2'b00, PH1=2'b10, PH2=2'b11, PH3=2'b01.
  - FSM state enum {PRIME, RUN}.
  - PRIME_CYCLES=2.
- One natural sub-module: sync2 (1-bit, two-flop, reset to 0), instantiated three times.
- Decode and the counter stay in quad_decoder. The next-phase lookup is a function in quad_pkg.

## Test plan
- Reset/prime: rst 1 cycle with a_in=b_in=1 held. Required: no step, err=0, cnt=0 through R+3 and beyond.
- Up count with wrap: N=8, load 8'hFE via en_load. Drive 00→10→11→01 spaced 4 cycles apart. Required: 3 step pulses, dir=1, cnt goes FE→FF→00→01, and each update lands 2 edges after the pin change is captured.
- Down count: from cnt=0x01, drive 00→01→11. Required: cnt 01→00→FF, dir=0, 2 steps.
- Illegal jump: from 00 drive 11. Required: err=1, no step, cnt unchanged. A further valid step still counts and err stays 1. en_load with load=0x10 gives err=0 and cnt=0x10.
- Priority collision: a valid up transition and an index rising edge reach the decode stage on the same cycle. Required: cnt=0, step=1, dir=1. Repeat with en_load=1, load=0x55 on the same cycle: cnt=0x55.
- Reset mid-run: assert rst while a transition is in the synchronizers. Required: no step after rst, all outputs at reset values, PRIME lasts 2 cycles.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared constants, types and helpers for the quadrature decoder.
//   DIR_UP / DIR_DN   : values presented on dir
//   PH0..PH3          : phase codes {a,b} in up-count order
//   state_t           : decoder FSM states
//   PRIME_CYCLES      : synchronizer fill cycles after reset
//   next_up()         : phase that follows a given phase when counting up
package quad_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  localparam int PRIME_CYCLES = 2;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Up order is PH0 -> PH1 -> PH2 -> PH3 -> PH0; the down step from X is the
  // phase whose up-successor is X.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins, load port and decoded outputs of quad_decoder.
//   a_in, b_in, idx_in : raw encoder pins (asynchronous to clk)
//   en_load, load      : synchronous position load
//   step, dir          : step event and its direction
//   cnt, err           : position count and sticky illegal-transition flag
// Handshake: there is no backpressure. step is a single-cycle strobe that is
// valid for exactly the clk cycle it is high; dir/cnt are valid alongside it
// and hold until the next event. en_load is accepted on every edge it is high.
// master = the side driving pins and load; slave = the decoder.
interface quad_decoder_if #(
  parameter int N = 8
);
  logic         a_in;
  logic         b_in;
  logic         idx_in;
  logic         en_load;
  logic [N-1:0] load;
  logic         step;
  logic         dir;
  logic [N-1:0] cnt;
  logic         err;

  modport master (
    output a_in, b_in, idx_in, en_load, load,
    input  step, dir, cnt, err
  );

  modport slave (
    input  a_in, b_in, idx_in, en_load, load,
    output step, dir, cnt, err
  );
endinterface

// File: rtl/sync2.sv
// sync2: 1-bit two-flop synchronizer, both flops cleared by rst.
//   clk : system clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output (second flop)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= 1'b0;
      q   <= 1'b0;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature decoder with loadable N-bit position counter.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : quad_decoder_if.slave (pins, load port, step/dir/cnt/err)
//   dbg_state : current FSM state (PRIME while synchronizers fill, then RUN)
module quad_decoder
  import quad_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  quad_decoder_if.slave   bus,
  output state_t          dbg_state
);

  localparam int          PW         = $clog2(PRIME_CYCLES + 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_CYCLES);

  // Synchronized pins and their previous-cycle copies.
  logic a_s, b_s, i_s;
  logic a_p, b_p, i_p;

  sync2 u_sync_a (.clk(clk), .rst(rst), .d(bus.a_in),   .q(a_s));
  sync2 u_sync_b (.clk(clk), .rst(rst), .d(bus.b_in),   .q(b_s));
  sync2 u_sync_i (.clk(clk), .rst(rst), .d(bus.idx_in), .q(i_s));

  // ---------------------------------------------------------------- FSM
  state_t        state_q, state_d;
  logic [PW-1:0] prime_q, prime_d;
  logic          decode_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRIME;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
    end
  end

  // PRIME covers the deassertion edge plus PRIME_CYCLES more, which is how
  // long it takes live pin values to reach the previous-value flops. Leaving
  // earlier would compare live pins against the reset zeros and report a
  // phantom step or illegal jump.
  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    case (state_q)
      PRIME: begin
        if (prime_q == PRIME_LAST) state_d = RUN;
        else                       prime_d = prime_q + PW'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    decode_en = (state_q == RUN);
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------- decode
  logic [1:0] ph_cur, ph_prv;
  logic       mv_up, mv_dn, changed;
  logic       step_ev, bad_ev, idx_rise;

  always_comb begin
    ph_cur   = {a_s, b_s};
    ph_prv   = {a_p, b_p};
    changed  = (ph_cur != ph_prv);
    // Equal phases never satisfy either test, since next_up has no fixed point.
    mv_up    = (ph_cur == next_up(ph_prv));
    mv_dn    = (ph_prv == next_up(ph_cur));
    step_ev  = decode_en && (mv_up || mv_dn);
    bad_ev   = decode_en && changed && !mv_up && !mv_dn;
    idx_rise = decode_en && i_s && !i_p;
  end

  // ---------------------------------------------------------------- datapath
  logic         step_q, dir_q, err_q;
  logic [N-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p    <= 1'b0;
      b_p    <= 1'b0;
      i_p    <= 1'b0;
      step_q <= 1'b0;
      dir_q  <= DIR_UP;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      a_p <= a_s;
      b_p <= b_s;
      i_p <= i_s;

      // step/dir report every valid transition, even when load or index
      // take the counter instead.
      step_q <= step_ev;
      if (step_ev) dir_q <= mv_up ? DIR_UP : DIR_DN;

      if (bus.en_load)  cnt_q <= bus.load;
      else if (idx_rise) cnt_q <= '0;
      else if (step_ev)  cnt_q <= mv_up ? cnt_q + N'(1) : cnt_q - N'(1);

      if (bus.en_load)  err_q <= 1'b0;
      else if (bad_ev)  err_q <= 1'b1;
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.cnt  = cnt_q;
  assign bus.err  = err_q;

endmodule
